// File: rtl/spike_mem_pkg.sv
// Shared types and helpers for the ping-pong spike memory.
// SPIKE_MEM_POPCNT_EN adds the rd_popcnt output in the top.
package spike_mem_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/spike_mem_pingpong_bank.sv
// One simple dual-port spike bank holding both pages.
// LAT=2 registers the read; LAT=1 reads combinationally.
module spike_bank
    import spike_mem_pkg::*;
#(
    parameter int WORD_W = 4,
    parameter int DEPTH  = 80,
    parameter int LAT    = 2,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    if (LAT >= 2) begin : g_sync
        always_ff @(posedge clk) begin
            if (re) rdata <= mem[raddr];
        end
    end else begin : g_async
        assign rdata = re ? mem[raddr] : '0;
    end

endmodule

// File: rtl/spike_mem_pingpong.sv
// Banked double-buffered spike memory with swap/auto-clear.
// Optional SPIKE_MEM_POPCNT_EN adds a registered rd_popcnt.
module spike_mem_pingpong
    import spike_mem_pkg::*;
#(
    parameter int WORD_W     = 4,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 40,
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = clog2(NUM_BANKS * BANK_DEPTH),
    parameter int BSEL_W     = clog2(NUM_BANKS)
`ifdef SPIKE_MEM_POPCNT_EN
    , parameter int PC_W     = clog2(NUM_BANKS * WORD_W + 1)
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [WORD_W-1:0]           wr_data,
    output logic                        wr_ready,
    input  logic                        rd_en,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic                        rd_ready,
    output logic                        rd_valid,
    output logic [WORD_W-1:0]           rd_data,
    output logic [NUM_BANKS*WORD_W-1:0] rd_data_wide,
    input  logic                        swap_req,
    output logic                        swap_done,
    output logic                        page_sel,
    output logic                        busy,
`ifdef SPIKE_MEM_POPCNT_EN
    output logic [PC_W-1:0]             rd_popcnt,
`endif
    output logic                        err_oob
);

    localparam int LAT   = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                           (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX :
                           RD_LATENCY;
    localparam int PD    = (LAT > 1) ? LAT - 1 : 1;
    localparam int ROW_W = ADDR_W - BSEL_W;
    localparam int PA_W  = clog2(2 * BANK_DEPTH);
    localparam int CNT_W = clog2(LAT + 1);
    localparam int WW    = NUM_BANKS * WORD_W;
    localparam logic [ADDR_W:0] LIMIT =
        (ADDR_W + 1)'(NUM_BANKS * BANK_DEPTH);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BANK_DEPTH - 1);

    state_t            state;
    logic              first_clr;
    logic [ROW_W-1:0]  clr_row;
    logic [CNT_W-1:0]  inflight;

    logic [BSEL_W-1:0] wr_bank, rd_bank;
    logic [ROW_W-1:0]  wr_row, rd_row;
    logic              wr_oob, rd_oob, wr_acc, rd_acc;

    // Pages sit back to back in each bank: page 1 starts at BANK_DEPTH.
    function automatic logic [PA_W-1:0] phys(
        input logic pg, input logic [ROW_W-1:0] row);
        return PA_W'(row) + (pg ? PA_W'(BANK_DEPTH) : PA_W'(0));
    endfunction

    assign wr_bank  = wr_addr[BSEL_W-1:0];
    assign wr_row   = wr_addr[ADDR_W-1:BSEL_W];
    assign rd_bank  = rd_addr[BSEL_W-1:0];
    assign rd_row   = rd_addr[ADDR_W-1:BSEL_W];
    assign wr_oob   = {1'b0, wr_addr} >= LIMIT;
    assign rd_oob   = {1'b0, rd_addr} >= LIMIT;

    assign wr_ready = (state == ST_RUN);
    assign rd_ready = (state != ST_DRAIN);
    assign busy     = (state != ST_RUN);
    assign wr_acc   = wr_en & wr_ready & ~wr_oob;
    assign rd_acc   = rd_en & rd_ready;

    logic [WORD_W-1:0] bank_q [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic              we;
        logic [PA_W-1:0]   wa;
        logic [WORD_W-1:0] wd;

        always_comb begin
            if (state == ST_CLEAR) begin
                we = 1'b1;
                wa = phys(~page_sel, clr_row);
                wd = '0;
            end else begin
                we = wr_acc && (wr_bank == BSEL_W'(b));
                wa = phys(~page_sel, wr_row);
                wd = wr_data;
            end
        end

        spike_bank #(
            .WORD_W(WORD_W),
            .DEPTH (2 * BANK_DEPTH),
            .LAT   (LAT),
            .AW    (PA_W)
        ) u_bank (
            .clk  (clk),
            .we   (we),
            .waddr(wa),
            .wdata(wd),
            .re   (rd_acc & ~rd_oob),
            .raddr(phys(page_sel, rd_row)),
            .rdata(bank_q[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_CLEAR;
            page_sel  <= 1'b0;
            clr_row   <= '0;
            swap_done <= 1'b0;
            first_clr <= 1'b1;
        end else begin
            swap_done <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    if (swap_req) begin
                        if (inflight == '0 && !rd_en) begin
                            page_sel <= ~page_sel;
                            clr_row  <= '0;
                            state    <= ST_CLEAR;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (inflight == '0) begin
                        page_sel <= ~page_sel;
                        clr_row  <= '0;
                        state    <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_row == LAST_ROW) begin
                        swap_done <= ~first_clr;
                        first_clr <= 1'b0;
                        state     <= ST_RUN;
                    end else begin
                        clr_row <= clr_row + 1'b1;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    logic [LAT-1:0]             vq, vs;
    logic [PD-1:0][BSEL_W-1:0]  bq;
    logic [LAT-1:0][BSEL_W-1:0] bs;
    logic [PD-1:0]              oq;
    logic [LAT-1:0]             os;

    // Stage 0 is the accept cycle; stage LAT-1 feeds the output register.
    always_comb begin
        vs    = '0;
        bs    = '0;
        os    = '0;
        vs[0] = rd_acc;
        bs[0] = rd_bank;
        os[0] = rd_oob;
        for (int i = 1; i < LAT; i++) begin
            vs[i] = vq[i-1];
            bs[i] = bq[i-1];
            os[i] = oq[i-1];
        end
    end

    assign rd_valid = vq[LAT-1];

    logic [WW-1:0]     pre_wide;
    logic [WORD_W-1:0] pre_narrow;

    always_comb begin
        pre_wide   = '0;
        pre_narrow = '0;
        if (!os[LAT-1]) begin
            for (int b = 0; b < NUM_BANKS; b++)
                pre_wide[(NUM_BANKS-1-b)*WORD_W +: WORD_W] = bank_q[b];
            pre_narrow = bank_q[bs[LAT-1]];
        end
    end

`ifdef SPIKE_MEM_POPCNT_EN
    function automatic logic [PC_W-1:0] ones(input logic [WW-1:0] v);
        logic [PC_W-1:0] c;
        c = '0;
        for (int i = 0; i < WW; i++) c = c + PC_W'(v[i]);
        return c;
    endfunction
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq           <= '0;
            bq           <= '0;
            oq           <= '0;
            inflight     <= '0;
            err_oob      <= 1'b0;
            rd_data      <= '0;
            rd_data_wide <= '0;
`ifdef SPIKE_MEM_POPCNT_EN
            rd_popcnt    <= '0;
`endif
        end else begin
            vq       <= vs;
            bq       <= bs[PD-1:0];
            oq       <= os[PD-1:0];
            inflight <= inflight + CNT_W'(rd_acc) - CNT_W'(rd_valid);
            if ((wr_en & wr_ready & wr_oob) | (rd_acc & rd_oob))
                err_oob <= 1'b1;
            if (vs[LAT-1]) begin
                rd_data      <= pre_narrow;
                rd_data_wide <= pre_wide;
`ifdef SPIKE_MEM_POPCNT_EN
                rd_popcnt    <= ones(pre_wide);
`endif
            end
        end
    end

endmodule

// File: tb/tb_spike_mem_pingpong.sv
// Directed scoreboard bench for spike_mem_pingpong.
// Checks rd_popcnt too when SPIKE_MEM_POPCNT_EN is defined.
module tb_spike_mem_pingpong;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [3:0]  wr_data;
    logic        wr_ready;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic        rd_ready;
    logic        rd_valid;
    logic [3:0]  rd_data;
    logic [15:0] rd_data_wide;
    logic        swap_req;
    logic        swap_done;
    logic        page_sel;
    logic        busy;
    logic        err_oob;
`ifdef SPIKE_MEM_POPCNT_EN
    logic [4:0]  rd_popcnt;
`endif

    spike_mem_pingpong dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_ready    (rd_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_data_wide(rd_data_wide),
        .swap_req    (swap_req),
        .swap_done   (swap_done),
        .page_sel    (page_sel),
        .busy        (busy),
`ifdef SPIKE_MEM_POPCNT_EN
        .rd_popcnt   (rd_popcnt),
`endif
        .err_oob     (err_oob)
    );

    typedef struct {
        logic [3:0]  d;
        logic [15:0] w;
        int          due;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  sd_cnt = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (swap_done) sd_cnt++;
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    chk("rd_valid_spurious", rd_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rd_latency", cyc, mon_e.due);
                    chk("rd_data", rd_data, mon_e.d);
                    chk("rd_data_wide", rd_data_wide, mon_e.w);
`ifdef SPIKE_MEM_POPCNT_EN
                    chk("rd_popcnt", rd_popcnt, $countones(mon_e.w));
`endif
                end
            end else if (sb.size() > 0 && sb[0].due < cyc) begin
                mon_e = sb.pop_front();
                chk("rd_valid_missing", rd_valid, 1);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [3:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        chk("wr_ready", wr_ready, 1);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a,
                      input logic [3:0] d,
                      input logic [15:0] w);
        rd_en   = 1'b1;
        rd_addr = a;
        sb.push_back('{d, w, cyc + 2});
        chk("rd_ready", rd_ready, 1);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wait_sd(input string tag, input int n0, input int lat);
        int n = 0;
        while (!swap_done && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_swap_done"}, swap_done, 1);
        chk({tag, "_swap_lat"}, cyc - n0, lat);
        tick();
        chk({tag, "_swap_done_1cyc"}, swap_done, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic swap_direct(input string tag, input logic pg);
        int n0 = cyc;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk({tag, "_page_sel"}, page_sel, pg);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_wr_ready_clear"}, wr_ready, 0);
        chk({tag, "_rd_ready_clear"}, rd_ready, 1);
        wait_sd(tag, n0, 41);
    endtask

    task automatic busy_len(input string tag);
        int n = 0;
        chk({tag, "_wr_ready"}, wr_ready, 0);
        while (busy && n < 200) begin
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, n, 40);
    endtask

    initial begin
        int n0;
        int n;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_en    = 1'b0;
        rd_addr  = '0;
        swap_req = 1'b0;
        ticks(3);

        chk("rst_page_sel", page_sel, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_wide", rd_data_wide, 0);
        chk("rst_swap_done", swap_done, 0);
        chk("rst_err_oob", err_oob, 0);
        chk("rst_busy", busy, 1);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_rd_ready", rd_ready, 1);
`ifdef SPIKE_MEM_POPCNT_EN
        chk("rst_popcnt", rd_popcnt, 0);
`endif

        rst_n = 1'b1;
        busy_len("init");
        tick();
        chk("init_no_swap_done", sd_cnt, 0);
        chk("init_page_sel", page_sel, 0);
        chk("init_busy", busy, 0);

        wr(8'd5, 4'hA);
        swap_direct("swap1", 1'b1);
        rd(8'd5, 4'hA, 16'h0A00);
        rd(8'd4, 4'h0, 16'h0A00);
        for (int a = 120; a < 124; a++) wr(8'(a), 4'hF);
        ticks(2);

        // read and write addr 6 together, then swap with reads in flight
        rd_en    = 1'b1;
        rd_addr  = 8'd6;
        wr_en    = 1'b1;
        wr_addr  = 8'd6;
        wr_data  = 4'h3;
        sb.push_back('{4'h0, 16'h0A00, cyc + 2});
        tick();
        wr_en    = 1'b0;
        rd_addr  = 8'd5;
        swap_req = 1'b1;
        sb.push_back('{4'hA, 16'h0A00, cyc + 2});
        tick();
        rd_en    = 1'b0;
        swap_req = 1'b0;
        chk("drain_rd_ready", rd_ready, 0);
        chk("drain_wr_ready", wr_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_page_hold", page_sel, 1);
        n = 0;
        while (page_sel && n < 20) begin
            tick();
            n++;
        end
        chk("drain_page_toggle", page_sel, 0);
        chk("drain_reads_done_first", sb.size(), 0);
        wait_sd("swap2", cyc, 40);

        rd(8'd5, 4'h0, 16'h0030);
        rd(8'd6, 4'h3, 16'h0030);
        rd(8'd120, 4'hF, 16'hFFFF);
        wr(8'd159, 4'h9);
        ticks(3);
        chk("oob_before", err_oob, 0);
        wr(8'd160, 4'hF);
        rd(8'd200, 4'h0, 16'h0000);
        ticks(4);
        chk("oob_set", err_oob, 1);
        chk("swap_count_2", sd_cnt, 2);

        // swap 3, reads during clear, then reset at clear row 17
        n0 = cyc;
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        chk("swap3_page_sel", page_sel, 1);
        chk("oob_sticky", err_oob, 1);
        tick();
        rd(8'd159, 4'h9, 16'h0009);
        rd(8'd0, 4'h0, 16'h0000);
        ticks(n0 + 16 - cyc);
        rd(8'd159, 4'h9, 16'h0009);
        @(posedge clk);
        #2;
        chk("pre_reset_valid", rd_valid, 1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_page_sel", page_sel, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_err_oob", err_oob, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_rd_ready", rd_ready, 1);
        ticks(3);
        rst_n = 1'b1;
        busy_len("rerun");
        tick();
        chk("rerun_page_sel", page_sel, 0);
        chk("rerun_swap_count", sd_cnt, 2);
        rd(8'd120, 4'hF, 16'hFFFF);
        ticks(4);
        chk("end_scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
